// File: rtl/fft_pkg.sv
// ----------------------------------------------------------------------------
// fft_pkg : constants and helpers shared by the radix-2^2 SDF FFT stages
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package fft_pkg;

  localparam int FFT_N     = 16;
  localparam int FFT_LOG_N = 4;
  localparam int TW_AW     = 4;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_e;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
    logic bypass;
    logic conj;
  } tw_flags_t;

  // Twiddle exponent for sample m: bit-swapped upper pair times lower pair.
  function automatic logic [TW_AW-1:0] tw_idx(input logic [FFT_LOG_N-1:0] m);
    logic [TW_AW-1:0] q;
    logic [TW_AW-1:0] r;
    q = {2'b00, m[2], m[3]};
    r = {2'b00, m[1:0]};
    return q * r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tw_seq_ctrl_if.sv
// ----------------------------------------------------------------------------
// tw_seq_ctrl_if : sample-side control in, twiddle address and aligned flags out
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface tw_seq_ctrl_if;
  import fft_pkg::*;

  logic             sync_clr;
  logic             in_valid;
  logic             in_last;
  logic             inv_in;
  logic [TW_AW-1:0] tw_addr;
  logic             out_valid;
  logic             out_first;
  logic             out_last;
  logic             out_bypass;
  logic             out_conj;
  logic             sync_err;

  modport master (
    output sync_clr, in_valid, in_last, inv_in,
    input  tw_addr, out_valid, out_first, out_last, out_bypass, out_conj, sync_err
  );

  modport slave (
    input  sync_clr, in_valid, in_last, inv_in,
    output tw_addr, out_valid, out_first, out_last, out_bypass, out_conj, sync_err
  );

endinterface

`default_nettype wire

// File: rtl/tw_align_pipe.sv
// ----------------------------------------------------------------------------
// tw_align_pipe : DEPTH-stage delay line (DEPTH=0 is a wire), async clear, sync flush
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tw_align_pipe #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 1
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             flush,
  input  wire logic [WIDTH-1:0] din,
  output logic      [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_comb
      logic unused_ctrl;
      assign unused_ctrl = ^{clk, rst_n, flush};
      assign dout        = din;
    end else begin : g_regs
      logic [WIDTH-1:0] stage_q [DEPTH];
      logic [WIDTH-1:0] stage_d [DEPTH];

      always_comb begin
        stage_d[0] = flush ? '0 : din;
        for (int i = 1; i < DEPTH; i++) begin
          stage_d[i] = flush ? '0 : stage_q[i-1];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= '0;
          end
        end else begin
          stage_q <= stage_d;
        end
      end

      assign dout = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/tw_seq_ctrl.sv
// ----------------------------------------------------------------------------
// tw_seq_ctrl : twiddle ROM address sequencer and control aligner, 16-pt SDF FFT
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tw_seq_ctrl
  import fft_pkg::*;
#(
  parameter int TW_LAT   = 1,
  parameter bit LAST_CHK = 1'b1
) (
  input  wire logic    clk,
  input  wire logic    rst_n,
  tw_seq_ctrl_if.slave bus
);

  seq_state_e           state_q, state_d;
  logic [FFT_LOG_N-1:0] cnt_q, cnt_d;
  logic                 inv_q, inv_d;
  logic                 sync_err_q, sync_err_d;

  logic [TW_AW-1:0]     addr;
  logic                 take;
  logic                 first;
  logic                 wrap;
  logic                 early_last;
  tw_flags_t            flags_in;
  tw_flags_t            flags_out;

  always_comb begin
    addr       = tw_idx(cnt_q);
    take       = bus.in_valid & ~bus.sync_clr;
    first      = take & (state_q == ST_IDLE);
    wrap       = (cnt_q == 4'(FFT_N - 1));
    early_last = LAST_CHK & bus.in_last & ~wrap;

    flags_in.valid  = take;
    flags_in.first  = first;
    flags_in.last   = take & (wrap | (LAST_CHK & bus.in_last));
    flags_in.bypass = take & (addr == '0);
    flags_in.conj   = take & (first ? bus.inv_in : inv_q);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    inv_d      = inv_q;
    sync_err_d = 1'b0;
    if (bus.sync_clr) begin
      cnt_d   = '0;
      state_d = ST_IDLE;
    end else if (bus.in_valid) begin
      if (first) begin
        inv_d = bus.inv_in;
      end
      // A premature in_last closes the frame; its sample still goes out.
      if (early_last) begin
        cnt_d      = '0;
        state_d    = ST_IDLE;
        sync_err_d = 1'b1;
      end else begin
        cnt_d   = cnt_q + 4'd1;
        state_d = wrap ? ST_IDLE : ST_RUN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      inv_q      <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      inv_q      <= inv_d;
      sync_err_q <= sync_err_d;
    end
  end

  tw_align_pipe #(
    .WIDTH ($bits(tw_flags_t)),
    .DEPTH (TW_LAT)
  ) u_align (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (bus.sync_clr),
    .din   (flags_in),
    .dout  (flags_out)
  );

  assign bus.tw_addr    = addr;
  assign bus.sync_err   = sync_err_q;
  assign bus.out_valid  = flags_out.valid;
  assign bus.out_first  = flags_out.first;
  assign bus.out_last   = flags_out.last;
  assign bus.out_bypass = flags_out.bypass;
  assign bus.out_conj   = flags_out.conj;

endmodule

`default_nettype wire

// File: tb/tb_tw_seq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_tw_seq_ctrl : directed bench for tw_seq_ctrl, TW_LAT=1 and TW_LAT=0 side by side
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_tw_seq_ctrl;

  localparam int P_SNAP  = 1;
  localparam int P_DELTA = 2;
  localparam int P_RST0  = 4;
  localparam int P_SAME  = 8;
  localparam int P_START = 16;
  localparam int P_ERR   = 32;
  localparam int P_TW5   = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sync_clr = 1'b0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic inv_in = 1'b0;

  always #5 clk = ~clk;

  tw_seq_ctrl_if bus1 ();
  tw_seq_ctrl_if bus0 ();

  assign bus1.sync_clr = sync_clr;
  assign bus1.in_valid = in_valid;
  assign bus1.in_last  = in_last;
  assign bus1.inv_in   = inv_in;
  assign bus0.sync_clr = sync_clr;
  assign bus0.in_valid = in_valid;
  assign bus0.in_last  = in_last;
  assign bus0.inv_in   = inv_in;

  tw_seq_ctrl #(.TW_LAT(1), .LAST_CHK(1'b1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  tw_seq_ctrl #(.TW_LAT(0), .LAST_CHK(1'b1)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

  // Reference model: sample index in frame, captured direction, pending error,
  // and the flag bundle of the previous cycle (what a 1-deep aligner shows).
  int          seq [16] = '{0, 0, 0, 0, 0, 2, 4, 6, 0, 1, 2, 3, 0, 3, 6, 9};
  int          m = 0;
  bit          inv_f = 1'b0;
  bit          err_e = 1'b0;
  logic [4:0]  d1 = '0;

  int          nchk = 0;
  int          nerr = 0;
  bit          run = 1'b0;
  int          pin = 0;
  int          tal  [6] = '{0, 0, 0, 0, 0, 0};
  int          snap [6] = '{0, 0, 0, 0, 0, 0};
  int          exp_t[6] = '{0, 0, 0, 0, 0, 0};
  string       tn   [6] = '{"out_valid", "out_first", "out_last", "out_bypass", "out_conj", "sync_err"};

  function automatic logic [4:0] flags(input bit v, input bit l, input bit inv, input bit clr);
    if (!v || clr) return 5'b0;
    return {1'b1, m == 0, (m == 15) || l, seq[m] == 0, (m == 0) ? inv : inv_f};
  endfunction

  function automatic void model_reset();
    m = 0; inv_f = 1'b0; err_e = 1'b0; d1 = '0;
  endfunction

  function automatic void model_update(input bit v, input bit l, input bit inv, input bit clr);
    if (!rst_n) begin
      model_reset();
      return;
    end
    d1    = flags(v, l, inv, clr);
    err_e = !clr && v && l && (m != 15);
    if (clr) begin
      m = 0;
    end else if (v) begin
      if (m == 0) inv_f = inv;
      m = err_e ? 0 : (m + 1) % 16;
    end
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    nchk++;
    if (act != expv) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (run) begin
      if ((pin & P_SNAP) != 0) begin
        for (int i = 0; i < 6; i++) snap[i] = tal[i];
      end
      if ((pin & P_DELTA) != 0) begin
        for (int i = 0; i < 6; i++) chk({"count_", tn[i]}, tal[i] - snap[i], exp_t[i]);
      end
      if ((pin & P_RST0) != 0)
        chk("async_reset_l1",
            int'({bus1.tw_addr, bus1.out_valid, bus1.out_first, bus1.out_last,
                  bus1.out_bypass, bus1.out_conj, bus1.sync_err}), 0);
      if ((pin & P_SAME) != 0)
        chk("same_cycle_valid", int'({bus0.out_valid, bus1.out_valid}), 2);
      if ((pin & P_START) != 0)
        chk("frame_start", int'({bus1.tw_addr, bus0.out_first}), 1);
      if ((pin & P_ERR) != 0)
        chk("sync_err_pulse", int'(bus1.sync_err), 1);
      if ((pin & P_TW5) != 0)
        chk("tw_addr_sample5", int'(bus1.tw_addr), 2);

      chk("tw_addr_l1", int'(bus1.tw_addr), seq[m]);
      chk("tw_addr_l0", int'(bus0.tw_addr), seq[m]);
      chk("flags_l1", int'({bus1.out_valid, bus1.out_first, bus1.out_last,
                            bus1.out_bypass, bus1.out_conj}), int'(d1));
      chk("flags_l0", int'({bus0.out_valid, bus0.out_first, bus0.out_last,
                            bus0.out_bypass, bus0.out_conj}),
          int'(flags(in_valid, in_last, inv_in, sync_clr)));
      chk("sync_err_l1", int'(bus1.sync_err), int'(err_e));
      chk("sync_err_l0", int'(bus0.sync_err), int'(err_e));

      tal[0] += int'(bus1.out_valid);
      tal[1] += int'(bus1.out_first);
      tal[2] += int'(bus1.out_last);
      tal[3] += int'(bus1.out_bypass);
      tal[4] += int'(bus1.out_conj);
      tal[5] += int'(bus1.sync_err);
    end
  end

  task automatic cyc(input bit v, input bit l, input bit inv, input bit clr, input int p);
    in_valid = v; in_last = l; inv_in = inv; sync_clr = clr; pin = p;
    @(posedge clk);
    #1;
    model_update(v, l, inv, clr);
    pin = 0;
  endtask

  task automatic idle(input int p);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, p);
  endtask

  task automatic frame(input bit inv_first, input bit inv_rest, input int p_first, input int p5);
    for (int i = 0; i < 16; i++)
      cyc(1'b1, i == 15, (i == 0) ? inv_first : inv_rest, 1'b0,
          (i == 0) ? p_first : ((i == 5) ? p5 : 0));
  endtask

  initial begin
    model_reset();
    run = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(0);
    idle(0);

    // back-to-back frame
    frame(1'b0, 1'b0, P_SNAP | P_SAME, P_TW5);
    idle(0);
    exp_t = '{16, 1, 1, 7, 0, 0};
    idle(P_DELTA);

    // frame with a gap after every sample
    for (int i = 0; i < 32; i++) begin
      if (i % 2 == 0) cyc(1'b1, (i / 2) == 15, 1'b0, 1'b0, (i == 0) ? P_SNAP : 0);
      else            idle(0);
    end
    idle(0);
    exp_t = '{16, 1, 1, 7, 0, 0};
    idle(P_DELTA);

    // premature in_last on sample 7, then an immediate full frame
    for (int k = 0; k < 8; k++) cyc(1'b1, k == 7, 1'b0, 1'b0, (k == 0) ? P_SNAP : 0);
    frame(1'b0, 1'b0, P_START | P_ERR, 0);
    idle(0);
    exp_t = '{24, 2, 2, 12, 0, 1};
    idle(P_DELTA);

    // sync_clr together with sample 5
    for (int k = 0; k < 5; k++) cyc(1'b1, 1'b0, 1'b0, 1'b0, (k == 0) ? P_SNAP : 0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 0);
    idle(0);
    exp_t = '{5, 1, 0, 5, 0, 0};
    idle(P_DELTA);
    frame(1'b0, 1'b0, P_START, 0);
    idle(0);

    // asynchronous reset while sample 10 is addressed
    for (int k = 0; k < 10; k++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 0);
    in_valid = 1'b0; in_last = 1'b0; inv_in = 1'b0; sync_clr = 1'b0;
    #1;
    rst_n = 1'b0;
    model_reset();
    pin = P_RST0;
    @(posedge clk);
    #1;
    pin = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(0);

    // inverse frame: inv_in only on the first sample
    frame(1'b1, 1'b0, P_SNAP | P_START, 0);
    idle(0);
    exp_t = '{16, 1, 1, 7, 16, 0};
    idle(P_DELTA);

    // forward frame: inv_in high everywhere except the first sample
    frame(1'b0, 1'b1, P_SNAP, 0);
    idle(0);
    exp_t = '{16, 1, 1, 7, 0, 0};
    idle(P_DELTA);

    idle(0);
    run = 1'b0;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tw_seq_ctrl.md
Name: tw_seq_ctrl

Overview:
Twiddle-address sequencer for the 16-point radix-2^2 SDF FFT twiddle multiplier stage. It counts incoming valid samples within 16-sample frames and drives the 4-bit address of the 16-entry twiddle ROM (W16^k, k=0..15). It delays the sample-side control (valid, first, last, bypass, conjugate) so that it arrives aligned with the ROM's registered twiddle output at the complex multiplier. It also detects frame-sync errors and resynchronises on them.

Parameters:
TW_LAT, 1, ROM read latency in cycles (0 or 1; 1 matches the registered ROM output); the out_* pipeline depth equals TW_LAT.
LAST_CHK, 1, 1 = check in_last against the sample counter; 0 = ignore in_last and rely on free-running frame wrap.

Ports:
clk  in  1  master clock, rising edge
rst_n  in  1  asynchronous active-low reset
sync_clr  in  1  synchronous clear: abort current frame, counter to 0
in_valid  in  1  sample present at multiplier input this cycle
in_last  in  1  marks final sample of a frame (qualified by in_valid)
inv_in  in  1  1 = inverse FFT; sampled on the first sample of each frame
tw_addr  out  4  twiddle ROM address for the current sample
out_valid  out  1  twiddle/sample pair valid at multiplier (delayed by TW_LAT)
out_first  out  1  aligned first-sample-of-frame flag
out_last  out  1  aligned last-sample-of-frame flag
out_bypass  out  1  aligned flag: twiddle index 0, multiplier may pass data through
out_conj  out  1  aligned flag: use conjugated twiddle (inverse transform)
sync_err  out  1  one-cycle pulse: in_last seen at count != 15

Behaviour:
- Reset (rst_n=0, async): cnt=0, state=IDLE, inv_q=0, every pipeline stage cleared. Outputs: tw_addr=0, all out_* flags=0, sync_err=0.
- Counter cnt[3:0] = sample index m in the frame. It advances only on in_valid=1 and wraps 15->0. Gaps (in_valid=0) hold cnt.
- Address function is combinational from registered cnt: q = {cnt[2],cnt[3]}, r = cnt[1:0], tw_addr = q*r (4-bit; max 9, so it never wraps).
  - Per-frame sequence: 0,0,0,0, 0,2,4,6, 0,1,2,3, 0,3,6,9.
  - tw_addr stays valid while in_valid=0, but downstream logic ignores it then.
- States:
  - IDLE: cnt=0, no frame open. in_valid moves to RUN; that sample is the first sample.
  - RUN: a frame is open. On the sample with cnt=15, the counter wraps and the state returns to IDLE.
- First-sample handling: first = in_valid & (cnt==0). inv_in is captured into inv_q on the first sample. conj for the current sample = inv_in on the first sample, otherwise inv_q.
- bypass = (tw_addr==0). last = in_valid & (cnt==15).
- Pipeline: {valid, first, last, bypass, conj} are registered TW_LAT times; out_* are the final stage. With TW_LAT=0 the out_* flags are combinational. A sample presented at cycle t appears on out_* at t+TW_LAT. ROM data for tw_addr(t) also lands at t+TW_LAT.
- Sync check (LAST_CHK=1):
  - in_valid & in_last & cnt!=15: sync_err pulses at t+1. That sample is still emitted with out_last=1. cnt goes to 0 and state to IDLE.
  - cnt==15 with in_last=0: the frame still wraps normally, no error (in_last is optional).
  - With LAST_CHK=0, sync_err stays 0.
- sync_clr=1: cnt goes to 0, state to IDLE, and all pipeline valid stages are cleared next cycle.
  - sync_clr has priority over a simultaneous in_valid; that sample is dropped (no out_valid).
- Reset mid-frame: immediate clear. No partial frame is resumed.

Decomposition:
- Shared package fft_pkg: FFT_N=16, FFT_LOG_N=4, TW_AW=4, and a twiddle-index function tw_idx(m) (swapped-bit q times r). Other radix-2^2 stages reuse the function.
- One natural sub-module: tw_align_pipe, a parameterised-depth (0..N) delay line with per-stage async clear and sync flush. It is used for the 5-bit flag bundle.

Test Plan:
- Reset then 16 back-to-back valids (inv_in=0, in_last on the 16th) -> tw_addr = 0,0,0,0,0,2,4,6,0,1,2,3,0,3,6,9. out_valid is high for 16 cycles, starting 1 cycle later (TW_LAT=1). out_first on the 1st, out_last on the 16th. out_bypass on samples 0-4, 8, 12. sync_err=0.
- Same frame with in_valid low on every other cycle -> identical address sequence on the valid cycles; out_valid follows the in_valid pattern delayed by 1; cnt holds during gaps.
- in_last asserted on sample 7 -> sync_err=1 for exactly one cycle. The next valid sample gets tw_addr=0 and out_first=1, and the full sequence restarts.
- sync_clr asserted together with in_valid at sample 5 -> no out_valid for that sample, pipeline flushed. The next valid is sample 0 with out_first=1.
- rst_n pulsed low mid-frame (sample 10) -> all outputs 0 immediately, asynchronously. After release, the first valid gives tw_addr=0 and out_first=1.
- inv_in=1 on the first sample only, then 0 -> out_conj=1 for all 16 samples of that frame. Next frame with inv_in=0 at its first sample -> out_conj=0. With TW_LAT=0 -> out_* coincide with in_valid in the same cycle.
